main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit for the 16-bit CPU. It sequences every instruction through fetch, decode, execute, memory and write-back states, and drives all datapath enables. It is the producer of the 2-bit ALUOp code that the ALU control unit consumes. Memory accesses use a ready handshake, so the block tolerates variable-latency instruction and data memory.

## Interface
Parameters:
- none; state and opcode encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state changes occur on its rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  instruction bits [15:12] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU input A select: 0 = PC, 1 = reg A.
- ALUSrcB  out  2  ALU input B select: 00 = reg B, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset.
- ALUOp  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = R-type, 11 = I-type.
- PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  illegal opcode trapped.
- state_o  out  4  current state, for debug.

## Operation
- Moore FSM. Outputs are decoded from the registered state; IRWrite, PCWrite and instr_done are additionally qualified by mem_ready where noted. Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Moves to DECODE when mem_ready=1; otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by opcode:
  - 0000, 0001 → R_EXEC
  - 0010, 1001, 1010, 1011 → I_EXEC
  - 0100 (LW), 0101 (SW) → MEM_ADDR
  - 0110 (BEQ) → BRANCH
  - 0111 (J) → JUMP
  - any other opcode → illegal handling (see Configuration)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1. Goes to MEM_WB on mem_ready; otherwise holds.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. instr_done=1. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready: instr_done=1, goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1. instr_done=1. Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0. instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. instr_done=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. instr_done=1. Goes to FETCH.

## Timing
- While reset=1, all outputs are forced to 0. On the first clk edge with reset=1, state becomes FETCH.
- Reset asserted mid-instruction, including during a memory wait, abandons the instruction. No write enable may be asserted in the cycle following that reset edge.
- Minimum cycles per instruction, assuming mem_ready=1 every cycle:
  - LW: 5
  - SW: 4
  - R-type, I-type: 4
  - BEQ, J: 3
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs stay stable during the wait.
- mem_ready outside memory states is ignored.
- Exactly one instr_done pulse per completed instruction; never asserted in FETCH.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE goes to TRAP. In TRAP, illegal_op=1 and all other outputs are 0. TRAP is left only by reset.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal opcode is executed as a NOP. DECODE goes straight to FETCH with instr_done=1. illegal_op is tied to 0 and the TRAP state does not exist.

## Structure
- Shared package ctrl_pkg holds:
  - state enum (4-bit encoding)
  - opcode constants
  - ALUOp, ALUSrcB and PCSource code constants
- One natural sub-module, ctrl_output_decoder: purely combinational state-to-control-word decoding. The top level holds the state register and next-state logic.

## Test plan
- Reset for 2 cycles, then release with mem_ready=1: state_o=FETCH, MemRead=1, IRWrite=1, PCWrite=1. All outputs are 0 while reset is high.
- opcode=0001 (ADD), mem_ready=1: states FETCH, DECODE, R_EXEC, R_WB; ALUOp=10 in R_EXEC; RegWrite=1 and RegDst=1 in R_WB; instr_done in cycle 4.
- opcode=0100 (LW), mem_ready low for 3 cycles in MEM_READ: total 8 cycles; MemtoReg=1 and RegWrite=1 in the final cycle; outputs stable during the wait.
- opcode=0110 (BEQ), then 0111 (J): PCWriteCond=1 with ALUOp=01 in cycle 3; then PCWrite=1 with PCSource=10 in cycle 3 of the jump.
- opcode=1111: with CTRL_ILLEGAL_TRAP_EN, illegal_op=1 and the FSM holds TRAP for 20 cycles, exiting only on reset. Without it, instr_done=1 in cycle 2, then FETCH.
- opcode=0101 (SW), reset asserted during a MEM_WRITE wait: next state FETCH with MemWrite=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit: state encoding,
// opcode map, datapath select codes and the control word driven per state.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
package ctrl_pkg;

  // 4-bit state encoding; FETCH is zero so the reset value and the
  // forced-zero debug output coincide.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_I_EXEC    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    ST_TRAP      = 4'd12
`endif
  } state_t;

  // Opcode map (instruction bits [15:12])
  localparam logic [3:0] OP_RTYPE_A = 4'b0000;
  localparam logic [3:0] OP_RTYPE_B = 4'b0001;
  localparam logic [3:0] OP_ITYPE_A = 4'b0010;
  localparam logic [3:0] OP_ITYPE_B = 4'b1001;
  localparam logic [3:0] OP_ITYPE_C = 4'b1010;
  localparam logic [3:0] OP_ITYPE_D = 4'b1011;
  localparam logic [3:0] OP_LW      = 4'b0100;
  localparam logic [3:0] OP_SW      = 4'b0101;
  localparam logic [3:0] OP_BEQ     = 4'b0110;
  localparam logic [3:0] OP_J       = 4'b0111;

  // ALU operation class handed to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // ALU input B select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls produced for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_word_t;

  // True for every opcode the decoder knows how to sequence
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_RTYPE_A, OP_RTYPE_B,
      OP_ITYPE_A, OP_ITYPE_B, OP_ITYPE_C, OP_ITYPE_D,
      OP_LW, OP_SW, OP_BEQ, OP_J: is_legal_op = 1'b1;
      default:                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm_decoder.sv
// Combinational state-to-control-word decoder for the main control unit.
// Moore outputs from the registered state; only IRWrite/PCWrite in FETCH and
// instr_done in MEM_WRITE look at mem_ready. Everything is zero under reset.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (decodes the TRAP state).
import ctrl_pkg::*;

module ctrl_output_decoder (
  input  state_t     state,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       decode_nop,
  output ctrl_word_t ctrl
);

  // Decode the current state into the datapath control word
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.iord      = 1'b0;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC only capture once the instruction word has arrived
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        ST_DECODE: begin
          // Precompute the branch target while the opcode is decoded
          ctrl.alu_src_a  = 1'b0;
          ctrl.alu_src_b  = SRCB_BROFF;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.instr_done = decode_nop;
        end
        ST_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        ST_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        ST_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_dst    = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        ST_MEM_WRITE: begin
          ctrl.mem_write  = 1'b1;
          ctrl.iord       = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        ST_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REGB;
          ctrl.alu_op    = ALUOP_RTYPE;
        end
        ST_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        ST_I_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ITYPE;
        end
        ST_I_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        ST_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REGB;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        ST_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_TRAP: begin
          ctrl.illegal_op = 1'b1;
        end
`endif
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 16-bit CPU. Holds the state register
// and next-state logic; ctrl_output_decoder turns the state into controls.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- illegal opcodes lock into
// TRAP until reset; when undefined they retire as a two-cycle NOP.
//
// Memory handshake: a request (MemRead/MemWrite with IorD) is held stable
// from the first cycle of FETCH/MEM_READ/MEM_WRITE until the cycle in which
// mem_ready is high; that cycle completes the access and the FSM advances on
// the following edge. mem_ready is ignored in every other state.
import ctrl_pkg::*;

module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     next_state;
  ctrl_word_t ctrl;
  logic       decode_nop;

  // An unknown opcode retires straight out of DECODE unless trapping is built in
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign decode_nop = 1'b0;
`else
  assign decode_nop = !is_legal_op(opcode);
`endif

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= next_state;
  end

  // Next-state selection from current state, opcode and memory completion
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE_A, OP_RTYPE_B:                         next_state = ST_R_EXEC;
          OP_ITYPE_A, OP_ITYPE_B, OP_ITYPE_C, OP_ITYPE_D: next_state = ST_I_EXEC;
          OP_LW, OP_SW:                                   next_state = ST_MEM_ADDR;
          OP_BEQ:                                         next_state = ST_BRANCH;
          OP_J:                                           next_state = ST_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                                        next_state = ST_TRAP;
`else
          default:                                        next_state = ST_FETCH;
`endif
        endcase
      end
      // IR still holds the instruction, so opcode splits load from store here
      ST_MEM_ADDR:  next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    next_state = ST_FETCH;
      ST_MEM_WRITE: next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    next_state = ST_R_WB;
      ST_R_WB:      next_state = ST_FETCH;
      ST_I_EXEC:    next_state = ST_I_WB;
      ST_I_WB:      next_state = ST_FETCH;
      ST_BRANCH:    next_state = ST_FETCH;
      ST_JUMP:      next_state = ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:      next_state = ST_TRAP;
`endif
      default:      next_state = ST_FETCH;
    endcase
  end

  // Output decode from the registered state
  ctrl_output_decoder u_decoder (
    .state      (state),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .decode_nop (decode_nop),
    .ctrl       (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign state_o     = reset ? 4'd0 : state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: instruction-level reference model producing
// per-cycle expected control words and cycle counts from the opcode class,
// the step sequence of each instruction and the memory wait pattern.
module tb_main_control_fsm;
  import ctrl_pkg::*;

  localparam int W = 22;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  state_t       step_q[$];
  int           done_cycle, done_cnt, total_waits, cyc;

  // Clock / reset
  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  function automatic logic [W-1:0] obs_word();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
            illegal_op, state_o};
  endfunction

  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001:                   return C_R;
      4'b0010, 4'b1001, 4'b1010, 4'b1011: return C_I;
      4'b0100:                            return C_LW;
      4'b0101:                            return C_SW;
      4'b0110:                            return C_BEQ;
      4'b0111:                            return C_J;
      default:                            return C_ILL;
    endcase
  endfunction

  function automatic int min_cycles(input int cls);
    case (cls)
      C_LW:         return 5;
      C_R, C_I, C_SW: return 4;
      C_BEQ, C_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  // Expected controls for one step of an instruction, straight from the
  // per-step control table; unlisted outputs are zero
  function automatic logic [W-1:0] model_ctrl(input state_t s, input logic mr, input logic [3:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      ST_FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: begin
        asb = 2'b11;
`ifndef CTRL_ILLEGAL_TRAP_EN
        done = (op_class(op) == C_ILL);
`endif
      end
      ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      ST_MEM_READ:  begin mrd = 1; iord = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
      ST_MEM_WRITE: begin mwr = 1; iord = 1; done = mr; end
      ST_R_EXEC:    begin asa = 1; aop = 2'b10; end
      ST_R_WB:      begin rw = 1; rdst = 1; done = 1; end
      ST_I_EXEC:    begin asa = 1; asb = 2'b10; aop = 2'b11; end
      ST_I_WB:      begin rw = 1; done = 1; end
      ST_BRANCH:    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      ST_JUMP:      begin pcw = 1; pcs = 2'b10; done = 1; end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:      ill = 1;
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill, 4'(s)};
  endfunction

  // Step sequence an instruction walks through
  task automatic build_steps(input logic [3:0] op);
    step_q = {};
    step_q.push_back(ST_FETCH);
    step_q.push_back(ST_DECODE);
    case (op_class(op))
      C_R:   begin step_q.push_back(ST_R_EXEC); step_q.push_back(ST_R_WB); end
      C_I:   begin step_q.push_back(ST_I_EXEC); step_q.push_back(ST_I_WB); end
      C_LW:  begin step_q.push_back(ST_MEM_ADDR); step_q.push_back(ST_MEM_READ); step_q.push_back(ST_MEM_WB); end
      C_SW:  begin step_q.push_back(ST_MEM_ADDR); step_q.push_back(ST_MEM_WRITE); end
      C_BEQ: step_q.push_back(ST_BRANCH);
      C_J:   step_q.push_back(ST_JUMP);
      default: ;
    endcase
  endtask

  // Driver: runs one instruction from FETCH; waits < 0 picks 0..2 at random.
  // Records observed and expected words for the calling test to compare.
  task automatic run_instr(input logic [3:0] op, input int fetch_waits, input int mem_waits);
    state_t s;
    logic   is_mem, mr;
    int     wl;
    build_steps(op);
    done_cycle = 0; done_cnt = 0; total_waits = 0; cyc = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      is_mem = (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
      wl = 0;
      if (is_mem) begin
        wl = (s == ST_FETCH) ? fetch_waits : mem_waits;
        if (wl < 0) wl = $urandom_range(0, 2);
      end
      total_waits += wl;
      for (int k = 0; k <= wl; k++) begin
        @(negedge clk);
        opcode    = (s == ST_FETCH) ? 4'($urandom_range(0, 15)) : op;
        mr        = is_mem ? (k == wl) : 1'($urandom_range(0, 1));
        mem_ready = mr;
        #1;
        cyc++;
        exp_q.push_back(model_ctrl(s, mr, op));
        obs_q.push_back(obs_word());
        if (instr_done === 1'b1) begin
          done_cnt++;
          if (done_cycle == 0) done_cycle = cyc;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      opcode    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (obs_word() !== '0) begin
        failures++;
        $display("FAIL reset_zero: got %h expected 0", obs_word());
      end
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'(ST_FETCH)) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", state_o, ST_FETCH);
    end
    checks++;
    if ({MemRead, IRWrite, PCWrite} !== 3'b111) begin
      failures++;
      $display("FAIL reset_fetch: got MemRead/IRWrite/PCWrite=%b expected 111", {MemRead, IRWrite, PCWrite});
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_rtype();
    logic [W-1:0] e, o;
    run_instr(4'b0001, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL rtype cycle%0d: got %h expected %h", i + 1, o, e); end
    end
    checks++;
    if (done_cycle != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL rtype_done: got cycle %0d count %0d expected cycle 4 count 1", done_cycle, done_cnt);
    end
  endtask

  task automatic test_lw_wait();
    logic [W-1:0] e, o;
    run_instr(4'b0100, 0, 3);
    for (int i = 4; i <= 6; i++) begin
      checks++;
      if (obs_q[i] !== obs_q[3]) begin
        failures++;
        $display("FAIL lw_stable cycle%0d: got %h expected %h", i + 1, obs_q[i], obs_q[3]);
      end
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL lw cycle%0d: got %h expected %h", i + 1, o, e); end
    end
    checks++;
    if (done_cycle != 8 || done_cnt != 1) begin
      failures++;
      $display("FAIL lw_done: got cycle %0d count %0d expected cycle 8 count 1", done_cycle, done_cnt);
    end
  endtask

  task automatic test_branch_jump();
    logic [W-1:0] e, o;
    logic [3:0]   ops[2];
    ops[0] = 4'b0110; ops[1] = 4'b0111;
    for (int n = 0; n < 2; n++) begin
      run_instr(ops[n], 0, 0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o !== e) begin failures++; $display("FAIL br_j op%b cycle%0d: got %h expected %h", ops[n], i + 1, o, e); end
      end
      checks++;
      if (done_cycle != 3 || done_cnt != 1) begin
        failures++;
        $display("FAIL br_j_done op%b: got cycle %0d count %0d expected cycle 3 count 1", ops[n], done_cycle, done_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] e, o;
    run_instr(4'b1111, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL illegal cycle%0d: got %h expected %h", i + 1, o, e); end
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL trap_done: got %0d pulses expected 0", done_cnt); end
    e = model_ctrl(ST_TRAP, 1'b0, 4'b1111);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      opcode    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (obs_word() !== e) begin failures++; $display("FAIL trap_hold cycle%0d: got %h expected %h", i, obs_word(), e); end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'(ST_FETCH) || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL trap_exit: got state %0d illegal_op %b expected %0d 0", state_o, illegal_op, ST_FETCH);
    end
`else
    checks++;
    if (done_cycle != 2 || done_cnt != 1) begin
      failures++;
      $display("FAIL nop_done: got cycle %0d count %0d expected cycle 2 count 1", done_cycle, done_cnt);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'(ST_FETCH) || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL nop_next: got state %0d illegal_op %b expected %0d 0", state_o, illegal_op, ST_FETCH);
    end
`endif
  endtask

  task automatic test_reset_mid_sw();
    @(negedge clk); opcode = 4'($urandom_range(0, 15)); mem_ready = 1'b1;
    @(negedge clk); opcode = 4'b0101; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk); mem_ready = 1'($urandom_range(0, 1));
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'(ST_MEM_WRITE) || MemWrite !== 1'b1) begin
        failures++;
        $display("FAIL sw_wait: got state %0d MemWrite %b expected %0d 1", state_o, MemWrite, ST_MEM_WRITE);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs_word() !== '0) begin failures++; $display("FAIL sw_reset_zero: got %h expected 0", obs_word()); end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'(ST_FETCH) || {MemWrite, RegWrite, PCWriteCond} !== 3'b000) begin
      failures++;
      $display("FAIL sw_after_reset: got state %0d MemWrite/RegWrite/PCWriteCond %b expected %0d 000",
               state_o, {MemWrite, RegWrite, PCWriteCond}, ST_FETCH);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, o;
    logic [3:0]   op;
    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(0, 15));
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (op_class(op) == C_ILL) op = 4'b0100;
`endif
      run_instr(op, -1, -1);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o !== e) begin failures++; $display("FAIL b2b n%0d op%b cycle%0d: got %h expected %h", n, op, i + 1, o, e); end
      end
      checks++;
      if (done_cycle != min_cycles(op_class(op)) + total_waits || done_cnt != 1) begin
        failures++;
        $display("FAIL b2b_done n%0d op%b: got cycle %0d count %0d expected cycle %0d count 1",
                 n, op, done_cycle, done_cnt, min_cycles(op_class(op)) + total_waits);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_reset_mid_sw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
